// File: rtl/dds_phase_acc_pkg.sv
// Shared definitions for the DDS phase accumulator slice.
// Holds the default widths, the FTW byte-loader state type and a helper
// that derives the number of bytes per frequency tuning word.
package dds_phase_acc_pkg;

    localparam int unsigned DEF_ACC_W  = 24;
    localparam int unsigned DEF_ADDR_W = 8;

    typedef enum logic {
        IDLE     = 1'b0,
        ASSEMBLE = 1'b1
    } loader_state_t;

    // Number of 8-bit bytes that make up one tuning word.
    function automatic int unsigned ftw_byte_count(input int unsigned acc_w);
        return acc_w / 8;
    endfunction

endpackage

// File: rtl/dds_phase_acc_ftw_byte_loader.sv
// FTW byte loader: assembles a tuning word from bytes sent MSB byte first.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   byte_in      - FTW byte
//   byte_valid   - byte_in valid this cycle
//   byte_first   - qualifies byte_valid, marks the MSB byte of a new word
//   word_done    - combinational: this edge completes a word
//   word         - the completed word (valid while word_done is high)
//   load_err     - registered one-cycle pulse for a continuation byte
//                  received outside a frame
module dds_phase_acc_ftw_byte_loader
    import dds_phase_acc_pkg::*;
#(
    parameter int unsigned ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    input  logic             byte_first,
    output logic             word_done,
    output logic [ACC_W-1:0] word,
    output logic             load_err
);

    localparam int unsigned N     = ftw_byte_count(ACC_W);
    // The count only ever holds 0..N-1; reaching N is the completion itself.
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    loader_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] asm_word;

    // The merged word is produced combinationally so the top can capture a
    // completed word on the same edge as the last byte arrives.
    always_comb begin
        word      = asm_word;
        word_done = 1'b0;
        if (byte_valid) begin
            if (byte_first) begin
                word                 = '0;
                word[ACC_W-1 -: 8]   = byte_in;
                word_done            = (N == 1);
            end else if (state == ASSEMBLE) begin
                for (int unsigned i = 1; i < N; i++) begin
                    if (cnt == CNT_W'(i)) begin
                        word[ACC_W-1-8*i -: 8] = byte_in;
                    end
                end
                word_done = (cnt == LAST_CNT);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            asm_word <= '0;
            load_err <= 1'b0;
        end else begin
            load_err <= 1'b0;
            if (byte_valid) begin
                if (byte_first || state == ASSEMBLE) begin
                    asm_word <= word;
                    if (word_done) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        state <= ASSEMBLE;
                        cnt   <= byte_first ? CNT_W'(1) : cnt + 1'b1;
                    end
                end else begin
                    load_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dds_phase_acc.sv
// DDS phase accumulator (NCO) driving the waveform LUT address.
// A tuning word is loaded over a byte interface and applied only at a
// phase wrap, on phase_clr, or while the accumulator is idle (ena=0).
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   ena          - advance enable; phase holds when low
//   phase_clr    - synchronous phase reset (wins over ena, never wraps)
//   byte_in, byte_valid, byte_first - FTW byte interface, MSB byte first
//   phase_addr   - LUT address, top ADDR_W bits of the accumulator
//   wrap_pulse   - one-cycle pulse after an accumulator carry-out
//   ftw_pending  - a complete FTW is waiting to be applied
//   load_err     - one-cycle pulse for an out-of-frame continuation byte
module dds_phase_acc
    import dds_phase_acc_pkg::*;
#(
    parameter int unsigned      ACC_W       = DEF_ACC_W,
    parameter int unsigned      ADDR_W      = DEF_ADDR_W,
    parameter logic [ACC_W-1:0] DEFAULT_FTW = ACC_W'(256)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              phase_clr,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    input  logic              byte_first,
    output logic [ADDR_W-1:0] phase_addr,
    output logic              wrap_pulse,
    output logic              ftw_pending,
    output logic              load_err
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] ftw;
    logic [ACC_W-1:0] pend_word;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             apply;
    logic             word_done;
    logic [ACC_W-1:0] word;

    dds_phase_acc_ftw_byte_loader #(
        .ACC_W (ACC_W)
    ) u_loader (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_first (byte_first),
        .word_done  (word_done),
        .word       (word),
        .load_err   (load_err)
    );

    assign sum   = {1'b0, acc} + {1'b0, ftw};
    // A carry only counts when the accumulator actually advances.
    assign carry = ena && !phase_clr && sum[ACC_W];
    assign apply = ftw_pending && (carry || phase_clr || !ena);

    assign phase_addr = acc[ACC_W-1 -: ADDR_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            ftw         <= DEFAULT_FTW;
            pend_word   <= '0;
            ftw_pending <= 1'b0;
            wrap_pulse  <= 1'b0;
        end else begin
            if (phase_clr) begin
                acc <= '0;
            end else if (ena) begin
                acc <= sum[ACC_W-1:0];
            end
            wrap_pulse <= carry;

            // Apply reads the old pend_word, so a word completing on this
            // same edge stays pending for the next apply opportunity.
            if (apply) begin
                ftw <= pend_word;
            end
            if (word_done) begin
                pend_word   <= word;
                ftw_pending <= 1'b1;
            end else if (apply) begin
                ftw_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dds_phase_acc.sv
// Self-checking bench for dds_phase_acc with a cycle model kept in the bench.
module tb_dds_phase_acc;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       phase_clr;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_first;
    logic [7:0] phase_addr;
    logic       wrap_pulse;
    logic       ftw_pending;
    logic       load_err;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    dds_phase_acc #(
        .ACC_W       (24),
        .ADDR_W      (8),
        .DEFAULT_FTW (24'h000100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .phase_clr   (phase_clr),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_first  (byte_first),
        .phase_addr  (phase_addr),
        .wrap_pulse  (wrap_pulse),
        .ftw_pending (ftw_pending),
        .load_err    (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    longint unsigned m_acc     = 0;
    longint unsigned m_ftw     = 64'h100;
    longint unsigned m_pend    = 0;
    bit              m_pending = 0;
    bit              m_wrap    = 0;
    bit              m_err     = 0;
    byte unsigned    frame[$];

    task automatic model_reset();
        m_acc = 0; m_ftw = 64'h100; m_pend = 0;
        m_pending = 0; m_wrap = 0; m_err = 0;
        frame.delete();
    endtask

    task automatic model_step();
        bit              done;
        longint unsigned w;
        longint unsigned s;
        bit              carry;
        bit              apply;
        done  = 0;
        w     = 0;
        m_err = 0;
        if (byte_valid) begin
            if (byte_first) begin
                frame.delete();
                frame.push_back(byte_in);
            end else if (frame.size() == 0) begin
                m_err = 1;
            end else begin
                frame.push_back(byte_in);
            end
            if (frame.size() == 3) begin
                w = (longint'(frame[0]) << 16) | (longint'(frame[1]) << 8) | longint'(frame[2]);
                done = 1;
                frame.delete();
            end
        end
        s     = m_acc + m_ftw;
        carry = !phase_clr && ena && (s >= 64'h1000000);
        apply = m_pending && (carry || phase_clr || !ena);
        if (phase_clr)  m_acc = 0;
        else if (ena)   m_acc = s % 64'h1000000;
        m_wrap = carry;
        if (apply) m_ftw = m_pend;
        if (done) begin
            m_pend = w;
            m_pending = 1;
        end else if (apply) begin
            m_pending = 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [7:0] exp_addr;
    always @(negedge clk) begin
        exp_addr = 8'(m_acc >> 16);
        n_checks++;
        if (phase_addr === exp_addr && wrap_pulse === m_wrap &&
            ftw_pending === m_pending && load_err === m_err) begin
            n_pass++;
        end else begin
            $display("FAIL cycle_model t=%0t got addr=%h wrap=%b pend=%b err=%b want addr=%h wrap=%b pend=%b err=%b",
                     $time, phase_addr, wrap_pulse, ftw_pending, load_err,
                     exp_addr, m_wrap, m_pending, m_err);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s got=0x%0h want=0x%0h", name, act, exp);
    endtask

    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic first);
        byte_valid = 1'b1;
        byte_first = first;
        byte_in    = b;
        step(1);
        byte_valid = 1'b0;
        byte_first = 1'b0;
    endtask

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned k;
        rst_n = 1'b0; ena = 1'b1; phase_clr = 1'b0;
        byte_in = 8'h00; byte_valid = 1'b0; byte_first = 1'b0;

        // Reset and default FTW
        step(3);
        chk("reset_addr", phase_addr, 8'h00);
        chk("reset_pending", ftw_pending, 0);
        chk("reset_wrap", wrap_pulse, 0);
        rst_n = 1'b1;
        step(256);
        chk("addr_after_256", phase_addr, 8'h01);
        step(60000 - 256);

        // Load 0x010000 mid-period; it must wait for the wrap
        send(8'h01, 1'b1);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        chk("pending_after_3rd", ftw_pending, 1);
        k = 0;
        while (!wrap_pulse && k < 6000) begin
            step(1);
            k++;
        end
        chk("wrap_edge_index", 60003 + k, 65536);
        chk("wrap_pulse_seen", wrap_pulse, 1);
        chk("addr_at_wrap", phase_addr, 8'h00);
        chk("pending_cleared_at_wrap", ftw_pending, 0);
        step(1);
        chk("new_ftw_addr1", phase_addr, 8'h01);
        chk("wrap_one_cycle", wrap_pulse, 0);
        step(1);
        chk("new_ftw_addr2", phase_addr, 8'h02);

        // Apply with ena=0
        ena = 1'b0; phase_clr = 1'b1;
        step(1);
        phase_clr = 1'b0;
        send(8'h80, 1'b1);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        chk("pending_ena0", ftw_pending, 1);
        step(1);
        chk("applied_ena0", ftw_pending, 0);
        chk("hold_ena0", phase_addr, 8'h00);
        ena = 1'b1;
        step(1);
        chk("half_addr_80", phase_addr, 8'h80);
        chk("half_wrap_0", wrap_pulse, 0);
        step(1);
        chk("half_addr_00", phase_addr, 8'h00);
        chk("half_wrap_1", wrap_pulse, 1);
        step(1);
        chk("half_addr_80b", phase_addr, 8'h80);
        chk("half_wrap_0b", wrap_pulse, 0);

        // Framing errors
        ena = 1'b0;
        send(8'h55, 1'b0);
        chk("lone_cont_err", load_err, 1);
        chk("lone_cont_no_pend", ftw_pending, 0);
        step(1);
        chk("err_one_cycle", load_err, 0);
        send(8'hAA, 1'b1);
        send(8'hBB, 1'b0);
        send(8'h00, 1'b1);
        send(8'h00, 1'b0);
        send(8'h10, 1'b0);
        chk("restart_pending", ftw_pending, 1);
        chk("restart_word", dut.pend_word, 24'h000010);
        chk("restart_no_err", load_err, 0);
        step(1);
        chk("restart_applied", ftw_pending, 0);

        // phase_clr priority at acc=0xFFFF00, ftw=0x000100
        send(8'hFF, 1'b1);
        send(8'hFF, 1'b0);
        send(8'h00, 1'b0);
        step(1);
        chk("ffff00_applied", ftw_pending, 0);
        phase_clr = 1'b1;
        step(1);
        phase_clr = 1'b0;
        ena = 1'b1;
        send(8'h00, 1'b1);
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        k = 0;
        while (dut.acc != 24'hFFFF00 && k < 64) begin
            step(1);
            k++;
        end
        chk("reach_ffff00_cycles", k, 4);
        chk("ftw100_applied", ftw_pending, 0);
        phase_clr = 1'b1;
        step(1);
        phase_clr = 1'b0;
        chk("clr_acc", dut.acc, 0);
        chk("clr_no_wrap", wrap_pulse, 0);

        // Async reset mid-load
        send(8'h12, 1'b1);
        send(8'h34, 1'b0);
        #3 rst_n = 1'b0;
        #2;
        chk("async_addr", phase_addr, 8'h00);
        chk("async_pending", ftw_pending, 0);
        chk("async_wrap", wrap_pulse, 0);
        chk("async_ftw", dut.ftw, 24'h000100);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(8'h56, 1'b0);
        chk("post_reset_err", load_err, 1);
        step(1);
        chk("post_reset_err_clear", load_err, 0);
        chk("post_reset_no_pend", ftw_pending, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
